controlador_compuerta: RTL and testbench

Parking-entrance gate controller: the device-under-test end of the existing entrance stimulus bench. Watches the entrance and gate-passage vehicle sensors, accepts an 8-bit PIN on each rising edge of `sEnter`, and opens and closes the gate. Raises a wrong-PIN alarm after repeated failures and a blocking alarm when a second vehicle tailgates through an open gate. All outputs are registered, Moore-style from state.

---
 rtl/controlador_pkg.sv | 23 ++
 rtl/detector_flanco.sv | 29 ++
 rtl/controlador_compuerta.sv | 128 ++++++++++++
 tb/tb_controlador_compuerta.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/controlador_pkg.sv
// -----------------------------------------------------------------------------
// controlador_pkg
// Shared types and defaults for the parking-gate controllers.
//   estado_t             : gate FSM states, binary encoded
//   PIN_DEFAULT          : the PIN that opens the gate
//   MAX_INTENTOS_DEFAULT : wrong PINs per vehicle before the wrong-PIN alarm
// -----------------------------------------------------------------------------
package controlador_pkg;

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        PIN     = 3'd1,
        ALARMA  = 3'd2,
        ABIERTA = 3'd3,
        PASANDO = 3'd4,
        CIERRE  = 3'd5,
        BLOQUEO = 3'd6
    } estado_t;

    localparam logic [7:0] PIN_DEFAULT          = 8'h38;
    localparam int         MAX_INTENTOS_DEFAULT = 3;

endpackage : controlador_pkg

// File: rtl/detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// Rising-edge detector built around one history flop.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; clears the history flop
//   d     : level input
//   pulso : high in the cycle where d is 1 and was 0 at the previous edge
// The pulse is combinational from d so that the consumer can act on the
// edge in the same cycle the level first appears.
// -----------------------------------------------------------------------------
module detector_flanco (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic pulso
);

    logic dQ;

    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clock) begin
        if (reset) dQ <= 1'b0;
        else       dQ <= d;
    end

    assign pulso = d & ~dQ;

endmodule : detector_flanco

// File: rtl/controlador_compuerta.sv
// -----------------------------------------------------------------------------
// controlador_compuerta
// Parking-entrance gate controller. Accepts a PIN on each rising edge of
// sEnter, opens the gate, closes it once the vehicle has passed, and raises
// alarms on repeated wrong PINs or on tailgating.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   sEntrada : vehicle present at entrance sensor
//   sSalida  : vehicle present at gate-passage sensor
//   sEnter   : PIN submit button (rising edge is the event)
//   sCode    : PIN value, sampled in the sEnter edge cycle
//   sAbrir   : gate open command
//   sCerrar  : gate close command (1-cycle pulse, or held while blocked)
//   sBloq    : gate blocked
//   sAlmInc  : wrong-PIN alarm
//   sAlmBloq : tailgating alarm
// All outputs are flops decoded from the next state, so they change on the
// same edge as the state itself.
// -----------------------------------------------------------------------------
module controlador_compuerta
    import controlador_pkg::*;
#(
    parameter logic [7:0] PIN          = PIN_DEFAULT,
    parameter int         MAX_INTENTOS = MAX_INTENTOS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sEntrada,
    input  logic       sSalida,
    input  logic       sEnter,
    input  logic [7:0] sCode,
    output logic       sAbrir,
    output logic       sCerrar,
    output logic       sBloq,
    output logic       sAlmInc,
    output logic       sAlmBloq
);

    localparam int CNT_W = $clog2(MAX_INTENTOS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_INTENTOS);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(MAX_INTENTOS - 1);

    estado_t          estado, estadoNext;
    logic [CNT_W-1:0] intentos, intentosNext;
    logic             enterEv, ok, bad, cuentaFallos;

    detector_flanco uFlanco (
        .clock (clock),
        .reset (reset),
        .d     (sEnter),
        .pulso (enterEv)
    );

    assign ok  = enterEv & (sCode == PIN);
    assign bad = enterEv & (sCode != PIN);

    // The PIN parameter shadows the imported state literal of the same name,
    // so the state is always referenced through the package scope here.
    assign cuentaFallos = (estado == controlador_pkg::PIN) ||
                          (estado == ALARMA) || (estado == BLOQUEO);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        estadoNext   = estado;
        intentosNext = intentos;

        case (estado)
            ESPERA: begin
                // A PIN edge arriving together with the vehicle is dropped.
                if (sEntrada) estadoNext = controlador_pkg::PIN;
            end
            controlador_pkg::PIN: begin
                if (ok)                                estadoNext = ABIERTA;
                else if (bad && intentos == CNT_ULTIMO) estadoNext = ALARMA;
                else if (!sEntrada && !enterEv)        estadoNext = ESPERA;
            end
            ALARMA: begin
                if (ok) estadoNext = ABIERTA;
            end
            ABIERTA: begin
                if (sEntrada && sSalida)       estadoNext = BLOQUEO;
                else if (!sEntrada && sSalida) estadoNext = PASANDO;
            end
            PASANDO: begin
                if (sEntrada && sSalida)        estadoNext = BLOQUEO;
                else if (!sEntrada && !sSalida) estadoNext = CIERRE;
            end
            CIERRE: begin
                estadoNext = ESPERA;
            end
            BLOQUEO: begin
                if (ok) estadoNext = ABIERTA;
            end
            default: begin
                estadoNext = ESPERA;
            end
        endcase

        if (ok || estadoNext == ESPERA)
            intentosNext = '0;
        else if (bad && cuentaFallos && intentos != CNT_MAX)
            intentosNext = intentos + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= ESPERA;
            intentos <= '0;
            sAbrir   <= 1'b0;
            sCerrar  <= 1'b0;
            sBloq    <= 1'b0;
            sAlmInc  <= 1'b0;
            sAlmBloq <= 1'b0;
        end else begin
            estado   <= estadoNext;
            intentos <= intentosNext;
            sAbrir   <= (estadoNext == ABIERTA) || (estadoNext == PASANDO);
            sCerrar  <= (estadoNext == CIERRE)  || (estadoNext == BLOQUEO);
            sBloq    <= (estadoNext == BLOQUEO);
            sAlmBloq <= (estadoNext == BLOQUEO);
            // While blocked, the wrong-PIN alarm tracks the saturated count.
            sAlmInc  <= (estadoNext == ALARMA) ||
                        ((estadoNext == BLOQUEO) && (intentosNext == CNT_MAX));
        end
    end

endmodule : controlador_compuerta

// File: tb/tb_controlador_compuerta.sv
// -----------------------------------------------------------------------------
// tb_controlador_compuerta
// Directed bench for controlador_compuerta with default PIN 8'h38 and three
// allowed wrong PINs. Outputs are checked as the vector
// {sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq}, 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_controlador_compuerta;
    import controlador_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       sEntrada, sSalida, sEnter;
    logic [7:0] sCode;
    logic       sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq;

    int tests  = 0;
    int failed = 0;

    localparam logic [4:0] O_NADA    = 5'b00000;
    localparam logic [4:0] O_ABIERTA = 5'b10000;
    localparam logic [4:0] O_CIERRE  = 5'b01000;
    localparam logic [4:0] O_BLOQ    = 5'b01101;
    localparam logic [4:0] O_BLOQALM = 5'b01111;
    localparam logic [4:0] O_ALARMA  = 5'b00010;

    controlador_compuerta dut (
        .clock    (clock),
        .reset    (reset),
        .sEntrada (sEntrada),
        .sSalida  (sSalida),
        .sEnter   (sEnter),
        .sCode    (sCode),
        .sAbrir   (sAbrir),
        .sCerrar  (sCerrar),
        .sBloq    (sBloq),
        .sAlmInc  (sAlmInc),
        .sAlmBloq (sAlmBloq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chkOut(input string tag, input logic [4:0] esperado);
        logic [4:0] obs;
        obs = {sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq};
        tests++;
        assert (obs === esperado) else begin
            failed++;
            $error("FAIL %s: outputs %b, expected %b", tag, obs, esperado);
        end
    endtask

    task automatic chkEstado(input string tag, input estado_t esperado);
        tests++;
        assert (dut.estado === esperado) else begin
            failed++;
            $error("FAIL %s: state %0d, expected %0d", tag, dut.estado, esperado);
        end
    endtask

    // Raises sEnter with a code and clocks the edge; sEnter is lowered again
    // so the caller's next tick provides the required low cycle.
    task automatic enviar(input logic [7:0] code);
        sCode  = code;
        sEnter = 1'b1;
        tick();
        sEnter = 1'b0;
    endtask

    // Vehicle passes through an open gate: 01 -> 00, then gate closes.
    task automatic cerrar(input string tag);
        sEntrada = 1'b0; sSalida = 1'b1; tick(); chkOut({tag, "_pasando"}, O_ABIERTA);
        sSalida  = 1'b0;                 tick(); chkOut({tag, "_cierre"},  O_CIERRE);
        tick(); chkOut({tag, "_espera"}, O_NADA);
        chkEstado({tag, "_estado"}, ESPERA);
    endtask

    task automatic hacerReset();
        reset = 1'b1; sEntrada = 1'b0; sSalida = 1'b0; sEnter = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sEntrada = 1'b0; sSalida = 1'b0; sEnter = 1'b0; sCode = 8'h00;

        // Reset state
        tick();
        chkOut("reset_out", O_NADA);
        chkEstado("reset_estado", ESPERA);
        reset = 1'b0;

        // 1. Basic pass
        sEntrada = 1'b1; tick(); chkOut("s1_pin", O_NADA);
        chkEstado("s1_estado_pin", controlador_pkg::PIN);
        enviar(8'h38);   chkOut("s1_abre", O_ABIERTA);
        tick();          chkOut("s1_abierta", O_ABIERTA);
        cerrar("s1");

        // Edge arriving together with the vehicle is dropped, holding is one event
        sEntrada = 1'b1; sCode = 8'h38; sEnter = 1'b1;
        tick(); chkOut("drop_entrada", O_NADA);
        tick(); chkOut("drop_mantenido", O_NADA);
        sEnter = 1'b0; tick();
        enviar(8'h38); chkOut("drop_reenvio", O_ABIERTA);
        tick();
        cerrar("drop");

        // 2. Two wrong then right
        sEntrada = 1'b1; tick();
        enviar(8'hDA); chkOut("s2_da", O_NADA); tick();
        enviar(8'h0F); chkOut("s2_0f", O_NADA); tick();
        enviar(8'h38); chkOut("s2_38", O_ABIERTA); tick();
        cerrar("s2");

        // 3. Lockout alarm
        sEntrada = 1'b1; tick();
        enviar(8'h56); chkOut("s3_56", O_NADA); tick();
        enviar(8'h6E); chkOut("s3_6e", O_NADA); tick();
        enviar(8'hFF); chkOut("s3_ff", O_ALARMA); tick();
        sEntrada = 1'b0; tick(); chkOut("s3_salida_veh", O_ALARMA);
        enviar(8'h01); chkOut("s3_01", O_ALARMA); tick();
        enviar(8'h38); chkOut("s3_38", O_ABIERTA); tick();
        cerrar("s3");

        // 4. Tailgating
        sEntrada = 1'b1; tick();
        enviar(8'h38); chkOut("s4_abre", O_ABIERTA); tick();
        sEntrada = 1'b0; sSalida = 1'b1; tick(); chkOut("s4_01", O_ABIERTA);
        sEntrada = 1'b1; sSalida = 1'b1; tick(); chkOut("s4_11", O_BLOQ);
        sEntrada = 1'b1; sSalida = 1'b0; tick(); chkOut("s4_10", O_BLOQ);
        enviar(8'h7D); chkOut("s4_7d", O_BLOQ); tick();
        enviar(8'h38); chkOut("s4_38", O_ABIERTA); tick();
        cerrar("s4");

        // 6a. Wrong-PIN alarm while blocked, then reset in BLOQUEO
        sEntrada = 1'b1; tick();
        enviar(8'h38); tick();
        sSalida = 1'b1; tick(); chkOut("s6_bloq", O_BLOQ);
        enviar(8'h11); chkOut("s6_bad1", O_BLOQ); tick();
        enviar(8'h22); chkOut("s6_bad2", O_BLOQ); tick();
        enviar(8'h33); chkOut("s6_bad3", O_BLOQALM); tick();
        enviar(8'h44); chkOut("s6_bad4_sat", O_BLOQALM); tick();
        reset = 1'b1; tick(); chkOut("s6_reset_bloq", O_NADA);
        chkEstado("s6_reset_bloq_estado", ESPERA);
        hacerReset();

        // 6b. Reset in ALARMA, then a fresh vehicle needs three wrong PINs again
        sEntrada = 1'b1; tick();
        enviar(8'h01); tick(); enviar(8'h02); tick();
        enviar(8'h03); chkOut("s6_alarma", O_ALARMA); tick();
        reset = 1'b1; tick(); chkOut("s6_reset_alarma", O_NADA);
        chkEstado("s6_reset_alarma_estado", ESPERA);
        reset = 1'b0; tick(); chkEstado("s6_fresco_pin", controlador_pkg::PIN);
        enviar(8'h01); chkOut("s6_fresco1", O_NADA); tick();
        enviar(8'h02); chkOut("s6_fresco2", O_NADA); tick();
        enviar(8'h03); chkOut("s6_fresco3", O_ALARMA); tick();
        hacerReset();

        // 5. Held sEnter counts once: two more wrong PINs are needed afterwards
        sEntrada = 1'b1; tick();
        sCode = 8'hFF; sEnter = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); chkOut($sformatf("s5_mantenido%0d", i), O_NADA);
        end
        sEnter = 1'b0; tick();
        enviar(8'hFF); chkOut("s5_segundo", O_NADA); tick();
        enviar(8'hFF); chkOut("s5_tercero", O_ALARMA); tick();
        hacerReset();
        chkOut("fin_reset", O_NADA);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_controlador_compuerta
